// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : parity modes, receiver state encodings and a vote helper
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_DATA       = 3'd2,
    S_PARITY     = 3'd3,
    S_STOP       = 3'd4,
    S_BREAK_WAIT = 3'd5
  } uart_rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : receive FIFO with head presented straight from storage
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q, count_d;
  logic             w_rd_ok, w_wr_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNTW'(DEPTH));
  assign w_rd_ok   = rd_en_i & ~empty_o;
  // A write into a full FIFO only lands when the head leaves in the same cycle
  assign w_wr_ok   = wr_en_i & (~full_o | w_rd_ok);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (w_wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_buffered.sv
// ============================================================================
// uart_rx_buffered : oversampling UART receiver feeding a receive FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                            i_Clock,
  input  logic                            i_Rst_n,
  input  logic                            i_Rx_Serial,
  input  logic                            i_Rx_Next,
  input  logic                            i_Err_Clr,
  output logic                            o_Rx_DV,
  output logic [DATA_BITS-1:0]            o_Rx_Byte,
  output logic                            o_Parity_Err,
  output logic                            o_Frame_Err,
  output logic                            o_Overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_Fifo_Count
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int CNTW = $clog2(FIFO_DEPTH+1);
  localparam int FW   = DATA_BITS + 2;

  localparam logic [CW-1:0] C_HALF  = CW'((CLKS_PER_BIT-1)/2);
  localparam logic [CW-1:0] C_V0    = CW'(CLKS_PER_BIT-3);
  localparam logic [CW-1:0] C_V1    = CW'(CLKS_PER_BIT-2);
  localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT-1);
  localparam logic [2:0]    C_LBIT  = 3'(DATA_BITS-1);
  localparam logic          C_LSTOP = 1'(STOP_BITS-1);

  logic                 sync1_q, sync2_q;
  uart_rx_state_e       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;

  logic                 w_rx, w_bit, w_ferr_now, w_xor;
  logic                 w_fifo_wr, w_pop, w_full, w_empty, w_ovr;
  logic [FW-1:0]        w_fifo_din, w_fifo_head;
  logic [CNTW-1:0]      w_count;

  assign w_rx       = sync2_q;
  assign w_bit      = majority3(vote_q[1], vote_q[0], w_rx);
  assign w_ferr_now = ferr_q | ~w_bit;
  assign w_xor      = (^data_q) ^ w_bit;
  assign w_fifo_din = {w_ferr_now, perr_q, data_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    vote_d    = vote_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    w_fifo_wr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!w_rx) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == C_HALF) begin
          cnt_d = '0;
          if (!w_rx) begin
            state_d = S_DATA;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA, S_PARITY, S_STOP: begin
        if (cnt_q == C_V0) vote_d[0] = w_rx;
        if (cnt_q == C_V1) vote_d[1] = w_rx;
        if (cnt_q != C_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (state_q == S_DATA) begin
            // LSB arrives first, so shifting right leaves it at bit 0
            data_d = {w_bit, data_q[DATA_BITS-1:1]};
            stop_d = 1'b0;
            if (bit_q == C_LBIT) begin
              state_d = (PARITY == PARITY_NONE) ? S_STOP : S_PARITY;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else if (state_q == S_PARITY) begin
            perr_d  = (PARITY == PARITY_ODD) ? ~w_xor : w_xor;
            state_d = S_STOP;
          end else begin
            ferr_d = w_ferr_now;
            if (stop_q == C_LSTOP) begin
              w_fifo_wr = 1'b1;
              state_d   = w_ferr_now ? S_BREAK_WAIT : S_IDLE;
            end else begin
              stop_d = 1'b1;
            end
          end
        end
      end
      S_BREAK_WAIT: begin
        if (w_rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      vote_q    <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= i_Rx_Serial;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      vote_q    <= vote_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign w_pop     = i_Rx_Next & ~w_empty;
  assign w_ovr     = w_fifo_wr & w_full & ~w_pop;
  assign overrun_d = (overrun_q & ~i_Err_Clr) | w_ovr;

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_Clock),
    .rst_ni    (i_Rst_n),
    .wr_en_i   (w_fifo_wr),
    .wr_data_i (w_fifo_din),
    .rd_en_i   (i_Rx_Next),
    .rd_data_o (w_fifo_head),
    .count_o   (w_count),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  // Head fields are forced to zero when empty so reset shows all-zero outputs
  assign o_Rx_DV      = ~w_empty;
  assign o_Rx_Byte    = w_empty ? '0 : w_fifo_head[DATA_BITS-1:0];
  assign o_Parity_Err = ~w_empty & w_fifo_head[DATA_BITS];
  assign o_Frame_Err  = ~w_empty & w_fifo_head[DATA_BITS+1];
  assign o_Overrun    = overrun_q;
  assign o_Fifo_Count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
// ============================================================================
// tb_uart_rx_buffered : directed checks on an 8N1 and a 7E2 receiver instance
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_buffered;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_a = 1'b0, rx_a = 1'b1, next_a = 1'b0, clr_a = 1'b0;
  logic       rst_b = 1'b0, rx_b = 1'b1, next_b = 1'b0, clr_b = 1'b0;
  logic       dv_a, perr_a, ferr_a, ovr_a;
  logic [7:0] byte_a;
  logic [2:0] cnt_a;
  logic       dv_b, perr_b, ferr_b, ovr_b;
  logic [6:0] byte_b;
  logic [2:0] cnt_b;

  int checks = 0;
  int errors = 0;
  bit seen;

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .i_Clock(clk), .i_Rst_n(rst_a), .i_Rx_Serial(rx_a), .i_Rx_Next(next_a),
    .i_Err_Clr(clr_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a), .o_Parity_Err(perr_a),
    .o_Frame_Err(ferr_a), .o_Overrun(ovr_a), .o_Fifo_Count(cnt_a)
  );

  uart_rx_buffered #(
    .CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .i_Clock(clk), .i_Rst_n(rst_b), .i_Rx_Serial(rx_b), .i_Rx_Next(next_b),
    .i_Err_Clr(clr_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b), .o_Parity_Err(perr_b),
    .o_Frame_Err(ferr_b), .o_Overrun(ovr_b), .o_Fifo_Count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // bits[] is LSB first, starting with the start bit; called on a falling edge
  task automatic send_a(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_a = bits[i];
      repeat (16) @(negedge clk);
    end
    rx_a = 1'b1;
  endtask

  task automatic send_b(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_b = bits[i];
      repeat (16) @(negedge clk);
    end
    rx_b = 1'b1;
  endtask

  task automatic frame_a(input logic [7:0] d);
    send_a({6'b0, 1'b1, d, 1'b0}, 10);
  endtask

  task automatic pop_a();
    next_a = 1'b1;
    @(negedge clk);
    next_a = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dv", 32'(dv_a), 32'd0);
    check("rst_byte", 32'(byte_a), 32'd0);
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_ovr", 32'(ovr_a), 32'd0);
    check("rst_ferr", 32'(ferr_a), 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 single frame
    frame_a(8'hA5);
    check("a5_dv", 32'(dv_a), 32'd1);
    check("a5_byte", 32'(byte_a), 32'hA5);
    check("a5_perr", 32'(perr_a), 32'd0);
    check("a5_ferr", 32'(ferr_a), 32'd0);
    check("a5_count", 32'(cnt_a), 32'd1);
    pop_a();
    check("a5_pop_count", 32'(cnt_a), 32'd0);
    check("a5_pop_dv", 32'(dv_a), 32'd0);

    // 7E2: 0x35 has four ones, so even parity bit is 0
    send_b({5'b0, 2'b11, 1'b1, 7'h35, 1'b0}, 11);
    check("7e2_bad_byte", 32'(byte_b), 32'h35);
    check("7e2_bad_perr", 32'(perr_b), 32'd1);
    check("7e2_bad_ferr", 32'(ferr_b), 32'd0);
    next_b = 1'b1;
    @(negedge clk);
    next_b = 1'b0;
    send_b({5'b0, 2'b11, 1'b0, 7'h35, 1'b0}, 11);
    check("7e2_good_byte", 32'(byte_b), 32'h35);
    check("7e2_good_perr", 32'(perr_b), 32'd0);
    check("7e2_good_count", 32'(cnt_b), 32'd1);

    // 5-clock glitch is rejected
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_count", 32'(cnt_a), 32'd0);
    check("glitch_state", 32'(dut_a.state_q), 32'(S_IDLE));

    // break: start + 8 data + 3 bit times of low stop
    rx_a = 1'b0;
    repeat (12 * 16) @(negedge clk);
    check("brk_count", 32'(cnt_a), 32'd1);
    check("brk_byte", 32'(byte_a), 32'h00);
    check("brk_ferr", 32'(ferr_a), 32'd1);
    check("brk_state", 32'(dut_a.state_q), 32'(S_BREAK_WAIT));
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    check("brk_idle", 32'(dut_a.state_q), 32'(S_IDLE));
    check("brk_count_after", 32'(cnt_a), 32'd1);
    pop_a();
    check("brk_pop", 32'(cnt_a), 32'd0);

    // overrun: five back-to-back frames into a depth-4 FIFO
    frame_a(8'h11);
    frame_a(8'h22);
    frame_a(8'h33);
    frame_a(8'h44);
    frame_a(8'h55);
    check("ovr_count", 32'(cnt_a), 32'd4);
    check("ovr_flag", 32'(ovr_a), 32'd1);
    check("ovr_head", 32'(byte_a), 32'h11);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("ovr_clr", 32'(ovr_a), 32'd0);

    // pop coincident with the write while full
    seen = 1'b0;
    fork
      frame_a(8'h66);
      begin
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          if (dut_a.w_fifo_wr) begin
            seen   = 1'b1;
            next_a = 1'b1;
            @(negedge clk);
            next_a = 1'b0;
          end
        end
      end
    join
    check("simul_seen", 32'(seen), 32'd1);
    check("simul_ovr", 32'(ovr_a), 32'd0);
    check("simul_count", 32'(cnt_a), 32'd4);
    check("simul_head0", 32'(byte_a), 32'h22);
    pop_a();
    check("simul_head1", 32'(byte_a), 32'h33);
    pop_a();
    check("simul_head2", 32'(byte_a), 32'h44);
    pop_a();
    check("simul_head3", 32'(byte_a), 32'h66);
    pop_a();
    check("simul_empty", 32'(cnt_a), 32'd0);

    // reset in the middle of DATA with an entry already buffered
    frame_a(8'h5A);
    check("mid_pre_count", 32'(cnt_a), 32'd1);
    rx_a = 1'b0;
    repeat (16 * 3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("mid_rst_dv", 32'(dv_a), 32'd0);
    check("mid_rst_byte", 32'(byte_a), 32'd0);
    check("mid_rst_count", 32'(cnt_a), 32'd0);
    check("mid_rst_ferr", 32'(ferr_a), 32'd0);
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    repeat (20) @(negedge clk);
    frame_a(8'hC3);
    check("mid_after_count", 32'(cnt_a), 32'd1);
    check("mid_after_byte", 32'(byte_a), 32'hC3);
    check("mid_after_ferr", 32'(ferr_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
